// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type plus arbiter state encoding and abort word
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, IACC, DACC, RECOVER} arb_state_t;
  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/arbiter_if.sv
// arbiter_if: datapath-side and RAM-side bundle of the memory arbiter
interface arbiter_if;
  import cpu_types_pkg::*;
  logic  iREN, ihit, dREN, dWEN, dhit;
  word_t iaddr, iload, daddr, dstore, dload;
  logic  ram_REN, ram_WEN, ram_ack;
  word_t ram_addr, ram_store, ram_load;
  modport dp (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload
  );
  modport ram (
    input  ram_REN, ram_WEN, ram_addr, ram_store,
    output ram_ack, ram_load
  );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: wait counter with clear, enable and terminal-count flag
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign tc_o = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbitration onto one RAM port with starvation bound and watchdog
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  output logic  ram_REN,
  output logic  ram_WEN,
  output word_t ram_addr,
  output word_t ram_store,
  input  logic  ram_ack,
  input  word_t ram_load,
  output logic  timeout_err
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  arb_state_t state_q, state_d;
  word_t addr_q, store_q;
  logic wen_q, dsel_q, keep_q, tc, acc, rec, grant, req_own, hit, force_i;
  logic [SW-1:0] dstreak_q;
  assign acc = state_q == IACC || state_q == DACC;
  assign rec = state_q == RECOVER;
  assign force_i = iREN && dstreak_q == SW'(MAX_DSTREAK);
  assign req_own = state_q == IACC ? iREN : (dREN || dWEN);
  always_comb begin
    state_d = state_q == IDLE ? (force_i ? IACC : (dREN || dWEN) ? DACC : iREN ? IACC : IDLE)
            : acc ? (ram_ack ? IDLE : tc ? RECOVER : state_q)
            : IDLE;
  end
  assign grant = state_q == IDLE && state_d != IDLE;
  always_ff @(posedge CLK) begin
    if (nRST) state_q <= IDLE;
    else state_q <= state_d;
  end
  // keep_q drops for good once the owner lets go of its request mid-access
  always_ff @(posedge CLK) begin
    if (nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      dsel_q  <= 1'b0;
      keep_q  <= 1'b0;
    end else if (grant) begin
      addr_q  <= state_d == IACC ? iaddr : daddr;
      store_q <= state_d == DACC ? dstore : '0;
      wen_q   <= state_d == DACC && dWEN;
      dsel_q  <= state_d == DACC;
      keep_q  <= 1'b1;
    end else if (acc) begin
      keep_q  <= keep_q && req_own;
    end
  end
  always_ff @(posedge CLK) begin
    if (nRST) dstreak_q <= '0;
    else if (grant)
      dstreak_q <= (state_d == DACC && iREN)
                 ? (dstreak_q == SW'(MAX_DSTREAK) ? dstreak_q : dstreak_q + 1'b1) : '0;
  end
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk  (CLK),
    .rst  (nRST),
    .clr_i(!acc),
    .en_i (acc && !ram_ack),
    .tc_o (tc)
  );
  assign ram_REN     = state_q == IACC || (state_q == DACC && !wen_q);
  assign ram_WEN     = state_q == DACC && wen_q;
  assign ram_addr    = acc ? addr_q : '0;
  assign ram_store   = ram_WEN ? store_q : '0;
  assign hit         = (acc && ram_ack && keep_q && req_own) || (rec && keep_q);
  assign ihit        = hit && !dsel_q;
  assign dhit        = hit && dsel_q;
  assign iload       = ihit ? (rec ? ARB_ERR_WORD : ram_load) : '0;
  assign dload       = dhit ? (rec ? ARB_ERR_WORD : ram_load) : '0;
  assign timeout_err = rec;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios checked against a transaction-level arbiter model
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int MAXD = 4;
  localparam int TMO  = 64;
  logic  CLK = 1'b0, nRST = 1'b1;
  logic  iREN, dREN, dWEN, ram_ack;
  word_t iaddr, daddr, dstore, ram_load;
  logic  ihit, dhit, ram_REN, ram_WEN, timeout_err;
  word_t iload, dload, ram_addr, ram_store;
  int checks = 0, failures = 0;
  bit armed = 0;
  int seq[$];
  int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_ack(ram_ack), .ram_load(ram_load), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    ram_ack = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // model: phase 0 waiting, 1 RAM access in flight, 2 abort cycle; owner 1 fetch, 2 data
  int m_phase = 0, m_own = 0, m_age = 0, m_streak = 0;
  bit m_wr = 0, m_keep = 0;
  word_t m_addr = '0, m_store = '0;

  function automatic bit m_req();
    return m_own == 1 ? iREN : (dREN || dWEN);
  endfunction

  always @(posedge CLK) begin
    if (nRST) begin
      m_phase = 0; m_own = 0; m_streak = 0; m_keep = 0;
    end else if (m_phase == 0) begin
      if (iREN && (m_streak == MAXD || !(dREN || dWEN))) begin
        m_own = 1; m_addr = iaddr; m_wr = 0; m_streak = 0; m_phase = 1;
      end else if (dREN || dWEN) begin
        m_own = 2; m_addr = daddr; m_wr = dWEN; m_store = dstore; m_phase = 1;
        m_streak = iREN ? (m_streak < MAXD ? m_streak + 1 : MAXD) : 0;
      end
      if (m_phase == 1) begin m_age = 0; m_keep = 1; end
    end else if (m_phase == 1) begin
      m_keep = m_keep && m_req();
      m_age++;
      if (ram_ack) m_phase = 0;
      else if (m_age == TMO) m_phase = 2;
    end else m_phase = 0;
  end

  always @(negedge CLK) begin : cmp
    bit acc, hit, wr;
    word_t ld;
    if (armed) begin
      acc = m_phase == 1;
      wr  = acc && m_own == 2 && m_wr;
      hit = (acc && ram_ack && m_keep && m_req()) || (m_phase == 2 && m_keep);
      ld  = m_phase == 2 ? ARB_ERR_WORD : ram_load;
      chkb("ram_REN", ram_REN, acc && !wr);
      chkb("ram_WEN", ram_WEN, wr);
      chk("ram_addr", ram_addr, acc ? m_addr : '0);
      chk("ram_store", ram_store, wr ? m_store : '0);
      chkb("ihit", ihit, hit && m_own == 1);
      chkb("dhit", dhit, hit && m_own == 2);
      chk("iload", iload, (hit && m_own == 1) ? ld : '0);
      chk("dload", dload, (hit && m_own == 2) ? ld : '0);
      chkb("timeout_err", timeout_err, m_phase == 2);
    end
  end

  initial begin
    #400000;
    $display("FAIL tb_time_limit actual=running required=finished");
    $fatal(1);
  end

  initial begin
    iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0;
    iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
    repeat (2) @(posedge CLK);
    #1;
    armed = 1;
    settle();
    chkb("rst_ren", ram_REN, 1'b0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_store", ram_store, 32'h0);
    tick(); nRST = 0;
    // single fetch, L = 2
    tick(); iREN = 1; iaddr = 32'h40;
    tick(); settle();
    chkb("f_ren_c1", ram_REN, 1'b1);
    chk("f_addr_c1", ram_addr, 32'h40);
    tick(); ram_ack = 1; ram_load = 32'h2108FFFF; settle();
    chkb("f_ren_c2", ram_REN, 1'b1);
    chkb("f_ihit_c2", ihit, 1'b1);
    chk("f_iload_c2", iload, 32'h2108FFFF);
    tick(); iREN = 0; ram_load = '0; settle();
    chkb("f_idle_c3", ram_REN, 1'b0);
    chkb("f_ihit_c3", ihit, 1'b0);
    // simultaneous fetch and data write: data first
    tick(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    tick(); ram_ack = 1; settle();
    chkb("s_wen", ram_WEN, 1'b1);
    chk("s_store", ram_store, 32'h12345678);
    chk("s_addr", ram_addr, 32'h80);
    chkb("s_dhit", dhit, 1'b1);
    chkb("s_no_ihit", ihit, 1'b0);
    tick(); dWEN = 0; settle();
    chkb("s_idle_gap", ram_WEN, 1'b0);
    tick(); ram_ack = 1; ram_load = 32'h0BADF00D; settle();
    chk("s_iaddr", ram_addr, 32'h44);
    chkb("s_ihit", ihit, 1'b1);
    tick(); iREN = 0; ram_load = '0;
    // starvation bound with L = 1
    tick(); iREN = 1; dREN = 1; iaddr = 32'h340; daddr = 32'h300;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 20) begin ram_ack = 1; ram_load = word_t'(k); end
      else begin iREN = 0; dREN = 0; end
      settle();
      if (dhit) seq.push_back(2);
      if (ihit) seq.push_back(1);
    end
    chk("starve_hits", seq.size(), 10);
    for (int i = 0; i < 10; i++) chk("starve_order", seq[i], exp_seq[i]);
    ram_load = '0;
    // watchdog abort
    tick(); dREN = 1; daddr = 32'h100;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 66) dREN = 0;
      settle();
      if (k == 64) chkb("wd_ren_last", ram_REN, 1'b1);
      if (k == 65) begin
        chkb("wd_ren_drop", ram_REN, 1'b0);
        chkb("wd_terr", timeout_err, 1'b1);
        chkb("wd_dhit", dhit, 1'b1);
        chk("wd_dload", dload, 32'hBAD1BAD1);
      end
      if (k == 66) chkb("wd_terr_clear", timeout_err, 1'b0);
    end
    // ack on the terminal watchdog count
    tick(); dREN = 1; daddr = 32'h104;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 64) begin ram_ack = 1; ram_load = 32'hCAFEF00D; end
      if (k == 65) begin dREN = 0; ram_load = '0; end
      settle();
      if (k == 64) begin
        chkb("tc_dhit", dhit, 1'b1);
        chk("tc_dload", dload, 32'hCAFEF00D);
        chkb("tc_no_terr", timeout_err, 1'b0);
      end
      if (k == 65) chkb("tc_after", timeout_err, 1'b0);
    end
    // fetch dropped mid-access
    tick(); iREN = 1; iaddr = 32'h200;
    tick(); iREN = 0; settle();
    chkb("drop_ren", ram_REN, 1'b1);
    tick(); ram_ack = 1; ram_load = 32'h55AA55AA; settle();
    chkb("drop_ihit", ihit, 1'b0);
    chk("drop_iload", iload, 32'h0);
    tick(); ram_load = '0;
    // read+write together is a write
    tick(); dREN = 1; dWEN = 1; daddr = 32'h120; dstore = 32'hA5A5A5A5;
    tick(); ram_ack = 1; settle();
    chkb("rw_wen", ram_WEN, 1'b1);
    chkb("rw_ren", ram_REN, 1'b0);
    chkb("rw_dhit", dhit, 1'b1);
    tick(); dREN = 0; dWEN = 0;
    // reset during a data access
    tick(); dREN = 1; daddr = 32'h180;
    tick(); settle();
    chkb("rm_ren", ram_REN, 1'b1);
    tick(); nRST = 1; dREN = 0;
    tick(); nRST = 0; settle();
    chkb("rm_ren_off", ram_REN, 1'b0);
    chk("rm_addr", ram_addr, 32'h0);
    chkb("rm_terr", timeout_err, 1'b0);
    tick(); ram_ack = 1; ram_load = 32'h77; settle();
    chkb("rm_late_ack", dhit, 1'b0);
    chk("rm_dload", dload, 32'h0);
    tick(); ram_load = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
